usb_rx_deframer: RTL

Serial-to-byte stage directly downstream of the USB differential receiver front end. It consumes that front end's registered NRZI line sample (`rx_diff_out`) and its field qualifiers, then performs NRZI decode, bit unstuffing, LSB-first byte assembly, PID check and CRC5/CRC16 residual check. It delivers a byte stream plus per-packet status to the protocol engine.

---
 rtl/usb_pkg.sv | 34 +++
 rtl/usb_rx_deframer_if.sv | 32 +++
 rtl/usb_rx_crc.sv | 43 ++++
 rtl/usb_rx_deframer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB receive deframer.
//   state_t    - deframer FSM states
//   pid_type_t - PID[1:0] packet class (selects CRC handling)
//   CRC5/CRC16 polynomials, presets and good residuals
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_BODY,
        ST_DROP,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PT_SPECIAL = 2'b00,
        PT_TOKEN   = 2'b01,
        PT_HSHK    = 2'b10,
        PT_DATA    = 2'b11
    } pid_type_t;

    localparam logic [4:0]  CRC5_POLY    = 5'h05;
    localparam logic [4:0]  CRC5_PRESET  = 5'h1F;
    localparam logic [4:0]  CRC5_RESID   = 5'h0C;
    localparam logic [15:0] CRC16_POLY   = 16'h8005;
    localparam logic [15:0] CRC16_PRESET = 16'hFFFF;
    localparam logic [15:0] CRC16_RESID  = 16'h800D;

    // A PID byte carries its check field as the complement of its type field.
    function automatic logic pid_check(input logic [7:0] p);
        return p[3:0] == ~p[7:4];
    endfunction

endpackage

// File: rtl/usb_rx_deframer_if.sv
// usb_rx_deframer_if: front-end qualifiers in, byte stream and packet status out.
//   slave  - the deframer (consumes line sample/qualifiers, drives bytes/status)
//   master - the environment (drives line sample/qualifiers, observes bytes/status)
interface usb_rx_deframer_if;
    logic        rx_diff_out;
    logic        pid;
    logic        eop;
    logic        error;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        rx_sop;
    logic        rx_done;
    logic [10:0] byte_cnt;
    logic        crc_ok;
    logic        crc_err;
    logic        pid_err;
    logic        stuff_err;
    logic        align_err;
    logic        ovf_err;

    modport slave (
        input  rx_diff_out, pid, eop, error,
        output rx_data, rx_data_valid, rx_sop, rx_done, byte_cnt,
               crc_ok, crc_err, pid_err, stuff_err, align_err, ovf_err
    );

    modport master (
        output rx_diff_out, pid, eop, error,
        input  rx_data, rx_data_valid, rx_sop, rx_done, byte_cnt,
               crc_ok, crc_err, pid_err, stuff_err, align_err, ovf_err
    );
endinterface

// File: rtl/usb_rx_crc.sv
// usb_rx_crc: serial receive-side CRC5/CRC16 residual checker.
//   gclk, reset_l - clock, async active-low reset
//   init          - preset the register (both widths share one preset)
//   bit_en        - shift din into the CRC this cycle
//   sel16         - 1: CRC16 (0x8005), 0: CRC5 (x^5+x^2+1) in bits [4:0]
//   din           - received bit
//   res_ok        - register holds the good residual for the selected width
module usb_rx_crc
    import usb_pkg::*;
(
    input  logic gclk,
    input  logic reset_l,
    input  logic init,
    input  logic bit_en,
    input  logic sel16,
    input  logic din,
    output logic res_ok
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            // Low five bits of the CRC16 preset double as the CRC5 preset.
            crc_d = CRC16_PRESET | {11'h0, CRC5_PRESET};
        end else if (bit_en) begin
            if (sel16)
                crc_d = {crc_q[14:0], 1'b0} ^ ((din ^ crc_q[15]) ? CRC16_POLY : 16'h0);
            else
                crc_d = {11'h0, crc_q[3:0], 1'b0} ^
                        ((din ^ crc_q[4]) ? {11'h0, CRC5_POLY} : 16'h0);
        end
    end

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) crc_q <= CRC16_PRESET;
        else          crc_q <= crc_d;
    end

    assign res_ok = sel16 ? (crc_q == CRC16_RESID) : (crc_q[4:0] == CRC5_RESID);

endmodule

// File: rtl/usb_rx_deframer.sv
// usb_rx_deframer: NRZI decode, bit unstuffing, LSB-first byte assembly,
// PID check and CRC residual check for one USB receive lane.
//   gclk, reset_l - one line sample per clock; async active-low reset
//   bus (slave)   - rx_diff_out/pid/eop/error in; rx_data, rx_data_valid,
//                   rx_sop, rx_done, byte_cnt and sticky status out
//   MAX_BYTES     - bytes strobed per packet before ovf_err
module usb_rx_deframer
    import usb_pkg::*;
#(
    parameter int MAX_BYTES = 1027
) (
    input logic              gclk,
    input logic              reset_l,
    usb_rx_deframer_if.slave bus
);

    localparam logic [10:0] MAX_B = 11'(MAX_BYTES);

    state_t      state_q, state_d;
    pid_type_t   ptype_q, ptype_d;
    logic        prev_q, prev_d;
    logic        pid_q, pid_d;
    logic [2:0]  ones_q, ones_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_data_valid_q, rx_data_valid_d;
    logic        rx_sop_q, rx_sop_d;
    logic        rx_done_q, rx_done_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic        chk_q, chk_d;
    logic        crc_ok_q, crc_ok_d;
    logic        crc_err_q, crc_err_d;
    logic        pid_err_q, pid_err_d;
    logic        stuff_err_q, stuff_err_d;
    logic        align_err_q, align_err_d;
    logic        ovf_err_q, ovf_err_d;

    logic       d_bit, pid_rise, take, end_pkt, good;
    logic       crc_init, crc_bit_en, crc_res_ok;
    logic [7:0] byte_nxt;

    assign d_bit    = ~(bus.rx_diff_out ^ prev_q);
    assign pid_rise = bus.pid & ~pid_q;
    assign byte_nxt = {d_bit, shift_q};

    usb_rx_crc u_crc (
        .gclk    (gclk),
        .reset_l (reset_l),
        .init    (crc_init),
        .bit_en  (crc_bit_en),
        .sel16   (ptype_q == PT_DATA),
        .din     (d_bit),
        .res_ok  (crc_res_ok)
    );

    // Packet-class acceptance, evaluated against the final byte count.
    always_comb begin
        good = 1'b0;
        case (ptype_q)
            PT_TOKEN: good = crc_res_ok && (byte_cnt_q == 11'd3);
            PT_DATA:  good = crc_res_ok && (byte_cnt_q >= 11'd3);
            default:  good = (byte_cnt_q == 11'd1);
        endcase
    end

    always_comb begin
        state_d         = state_q;
        ptype_d         = ptype_q;
        prev_d          = prev_q;
        pid_d           = bus.pid;
        ones_d          = ones_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        rx_data_d       = rx_data_q;
        rx_data_valid_d = 1'b0;
        rx_sop_d        = 1'b0;
        rx_done_d       = 1'b0;
        byte_cnt_d      = byte_cnt_q;
        chk_d           = chk_q;
        crc_ok_d        = crc_ok_q;
        crc_err_d       = crc_err_q;
        pid_err_d       = pid_err_q;
        stuff_err_d     = stuff_err_q;
        align_err_d     = align_err_q;
        ovf_err_d       = ovf_err_q;
        crc_init        = 1'b0;
        crc_bit_en      = 1'b0;
        take            = 1'b0;
        end_pkt         = 1'b0;

        if (!bus.eop) prev_d = bus.rx_diff_out;

        case (state_q)
            ST_IDLE: begin
                // The cycle pid rises already carries the first PID bit.
                if (pid_rise && !bus.eop) begin
                    state_d     = ST_PID;
                    rx_sop_d    = 1'b1;
                    crc_init    = 1'b1;
                    byte_cnt_d  = 11'd0;
                    ptype_d     = PT_SPECIAL;
                    chk_d       = 1'b0;
                    crc_ok_d    = 1'b0;
                    crc_err_d   = 1'b0;
                    pid_err_d   = 1'b0;
                    stuff_err_d = 1'b0;
                    align_err_d = 1'b0;
                    ovf_err_d   = 1'b0;
                    take        = 1'b1;
                end
            end
            ST_PID, ST_BODY: begin
                if (bus.eop) begin
                    state_d = ST_DONE;
                    end_pkt = 1'b1;
                end else begin
                    take = 1'b1;
                end
            end
            ST_DROP: begin
                if (bus.eop) begin
                    state_d = ST_DONE;
                    end_pkt = 1'b1;
                end
            end
            ST_DONE: begin
                // ones/bit counters must be zero when IDLE hands over the first bit.
                state_d   = ST_IDLE;
                ones_d    = 3'd0;
                bit_cnt_d = 3'd0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            if (ones_q == 3'd6) begin
                // Six 1s: this bit must be the stuffed 0.
                if (d_bit) begin
                    stuff_err_d = 1'b1;
                    state_d     = ST_DROP;
                end else begin
                    ones_d = 3'd0;
                end
            end else begin
                ones_d     = d_bit ? ones_q + 3'd1 : 3'd0;
                shift_d    = byte_nxt[7:1];
                bit_cnt_d  = bit_cnt_q + 3'd1;
                crc_bit_en = (state_q == ST_BODY);
                if (bit_cnt_q == 3'd7) begin
                    if (byte_cnt_q != 11'h7FF) byte_cnt_d = byte_cnt_q + 11'd1;
                    if (byte_cnt_q >= MAX_B) begin
                        ovf_err_d = 1'b1;
                    end else begin
                        rx_data_d       = byte_nxt;
                        rx_data_valid_d = 1'b1;
                    end
                    if (state_q == ST_PID) begin
                        if (pid_check(byte_nxt) && !bus.error) begin
                            state_d = ST_BODY;
                            ptype_d = pid_type_t'(byte_nxt[1:0]);
                            chk_d   = 1'b1;
                        end else begin
                            pid_err_d = 1'b1;
                            state_d   = ST_DROP;
                        end
                    end
                end
            end
        end

        if (end_pkt) begin
            rx_done_d   = 1'b1;
            align_err_d = align_err_q | (bit_cnt_q != 3'd0);
            crc_ok_d    = chk_q & good &
                          ~(pid_err_q | stuff_err_q | ovf_err_q | align_err_d);
            crc_err_d   = chk_q & ~crc_ok_d;
        end
    end

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            state_q         <= ST_IDLE;
            ptype_q         <= PT_SPECIAL;
            prev_q          <= 1'b1;
            pid_q           <= 1'b0;
            ones_q          <= 3'd0;
            bit_cnt_q       <= 3'd0;
            shift_q         <= 7'h00;
            rx_data_q       <= 8'h00;
            rx_data_valid_q <= 1'b0;
            rx_sop_q        <= 1'b0;
            rx_done_q       <= 1'b0;
            byte_cnt_q      <= 11'd0;
            chk_q           <= 1'b0;
            crc_ok_q        <= 1'b0;
            crc_err_q       <= 1'b0;
            pid_err_q       <= 1'b0;
            stuff_err_q     <= 1'b0;
            align_err_q     <= 1'b0;
            ovf_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptype_q         <= ptype_d;
            prev_q          <= prev_d;
            pid_q           <= pid_d;
            ones_q          <= ones_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            rx_data_q       <= rx_data_d;
            rx_data_valid_q <= rx_data_valid_d;
            rx_sop_q        <= rx_sop_d;
            rx_done_q       <= rx_done_d;
            byte_cnt_q      <= byte_cnt_d;
            chk_q           <= chk_d;
            crc_ok_q        <= crc_ok_d;
            crc_err_q       <= crc_err_d;
            pid_err_q       <= pid_err_d;
            stuff_err_q     <= stuff_err_d;
            align_err_q     <= align_err_d;
            ovf_err_q       <= ovf_err_d;
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_data_valid = rx_data_valid_q;
    assign bus.rx_sop        = rx_sop_q;
    assign bus.rx_done       = rx_done_q;
    assign bus.byte_cnt      = byte_cnt_q;
    assign bus.crc_ok        = crc_ok_q;
    assign bus.crc_err       = crc_err_q;
    assign bus.pid_err       = pid_err_q;
    assign bus.stuff_err     = stuff_err_q;
    assign bus.align_err     = align_err_q;
    assign bus.ovf_err       = ovf_err_q;

endmodule
